result_capture_fifo: RTL and testbench

//  Consumer end of the processor-output interface: samples p_o/flag/control_signal each clock
//  and buffers valid results in a FIFO. Drains them to a host/debug port over a valid/ready handshake.

---
 rtl/proc_pkg.sv | 15 +
 rtl/result_fifo_mem.sv | 24 ++
 rtl/result_capture_fifo.sv | 164 ++++++++++++++++
 tb/tb_result_capture_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor-interface encodings: control_signal values and result-source tags.
package proc_pkg;

  localparam logic [1:0] CTRL_ALU = 2'b01;
  localparam logic [1:0] CTRL_MEM = 2'b10;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // True when control_signal names a real result producer.
  function automatic logic is_result(input logic [1:0] ctrl);
    return (ctrl == CTRL_ALU) || (ctrl == CTRL_MEM);
  endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// Entry storage for the result capture FIFO: sync write, combinational read, no reset.
module result_fifo_mem #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_capture_fifo.sv
// Captures valid processor results into a FIFO and drains them over valid/ready.
// Optional feature macro: RESULT_SEQ_EN adds a per-entry sequence stamp and the out_seq port.
module result_capture_fifo
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
`ifdef RESULT_SEQ_EN
  parameter int unsigned SEQ_W  = 8,
`endif
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_flag,
  input  logic [1:0]               in_ctrl,
  input  logic                     capture_en,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_src,
`ifdef RESULT_SEQ_EN
  output logic [SEQ_W-1:0]         out_seq,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef RESULT_SEQ_EN
  localparam int unsigned EW = DATA_W + 1 + SEQ_W;
`else
  localparam int unsigned EW = DATA_W + 1;
`endif

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
`ifdef RESULT_SEQ_EN
  logic [SEQ_W-1:0]  seq_q, seq_d, oseq_q, oseq_d;
`endif

  logic          wr_req, rd, full, wr_en, rd_en, drop, in_src;
  logic [EW-1:0] wdata, rdata, head;

  assign wr_req = in_flag & capture_en & is_result(in_ctrl);
  assign rd     = valid_q & out_ready;
  assign full   = (count_q == CW'(DEPTH));
  assign wr_en  = wr_req & (~full | rd) & ~clear;
  assign rd_en  = rd & ~clear;
  assign drop   = wr_req & full & ~rd & ~clear;
  assign in_src = (in_ctrl == CTRL_MEM) ? SRC_MEM : SRC_ALU;

`ifdef RESULT_SEQ_EN
  assign wdata = {seq_q, in_src, in_data};
`else
  assign wdata = {in_src, in_data};
`endif

  result_fifo_mem #(.WIDTH(EW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(wdata),
    .raddr_i(rd_ptr_d),
    .rdata_o(rdata)
  );

  // Pointer, occupancy, drop and sequence next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(rd_en);
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
`ifdef RESULT_SEQ_EN
    seq_d      = seq_q + SEQ_W'(wr_en);
`endif
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + DROP_W'(1);
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
`ifdef RESULT_SEQ_EN
      seq_d      = '0;
`endif
    end
  end

  // Next head entry; forwards the incoming word when it lands in the slot being exposed.
  always_comb begin
    head    = (wr_en && (wr_ptr_q == rd_ptr_d)) ? wdata : rdata;
    valid_d = (count_d != '0);
    data_d  = data_q;
    src_d   = src_q;
`ifdef RESULT_SEQ_EN
    oseq_d  = oseq_q;
`endif
    if (valid_d) begin
      data_d = head[DATA_W-1:0];
      src_d  = head[DATA_W];
`ifdef RESULT_SEQ_EN
      oseq_d = head[EW-1 -: SEQ_W];
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      src_q      <= 1'b0;
`ifdef RESULT_SEQ_EN
      seq_q      <= '0;
      oseq_q     <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      src_q      <= src_d;
`ifdef RESULT_SEQ_EN
      seq_q      <= seq_d;
      oseq_q     <= oseq_d;
`endif
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_src    = src_q;
`ifdef RESULT_SEQ_EN
  assign out_seq    = oseq_q;
`endif
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_result_capture_fifo.sv
// Directed self-checking bench for result_capture_fifo (DEPTH=8, DATA_W=32, DROP_W=8).
module tb_result_capture_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DROP_W = 8;
`ifdef RESULT_SEQ_EN
  localparam int unsigned SEQ_W  = 2;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_flag;
  logic [1:0]        in_ctrl;
  logic              capture_en;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
`ifdef RESULT_SEQ_EN
  logic [SEQ_W-1:0]  out_seq;
`endif
  logic [3:0]        count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  int checks = 0;
  int errors = 0;

  result_capture_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH),
`ifdef RESULT_SEQ_EN
    .SEQ_W(SEQ_W),
`endif
    .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_flag(in_flag), .in_ctrl(in_ctrl),
    .capture_en(capture_en), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src),
`ifdef RESULT_SEQ_EN
    .out_seq(out_seq),
`endif
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_flag = 1'b0; in_ctrl = 2'b00; in_data = '0;
    capture_en = 1'b1; clear = 1'b0; out_ready = 1'b0;
  endtask

  task automatic write_one(input logic [1:0] ctrl, input logic [DATA_W-1:0] d);
    in_flag = 1'b1; in_ctrl = ctrl; in_data = d;
    step();
    in_flag = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #2;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", out_data); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got ovf=%b drops=%0d exp 0/0", overflow, drop_count); end
    step();
    reset = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) write_one(2'b01, DATA_W'(i));
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL reset_prefill: got %0d exp 3", count); end
    reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_async: got count=%0d valid=%b exp 0/0", count, out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_async_data: got %h exp 0", out_data); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    idle();
    out_ready = 1'b1;
    write_one(2'b01, 32'h0000_0005);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h5 || out_src !== 1'b0) begin errors++; $display("FAIL single_head: got v=%b d=%h s=%b exp 1/5/0", out_valid, out_data, out_src); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", count); end
    step();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got count=%0d v=%b exp 0/0", count, out_valid); end
    checks++; if (out_data !== 32'h5) begin errors++; $display("FAIL single_hold: got %h exp 5", out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_burst();
    logic [DATA_W-1:0] exp_d [3];
    exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
    idle();
    for (int i = 0; i < 3; i++) write_one(2'b10, exp_d[i]);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL burst_count: got %0d exp 3", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_src !== 1'b1) begin errors++; $display("FAIL burst_read%0d: got v=%b d=%h s=%b exp 1/%h/1", i, out_valid, out_data, out_src, exp_d[i]); end
      step();
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL burst_empty: got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    idle();
    for (int i = 0; i < 8; i++) write_one(2'b01, 32'h100 + DATA_W'(i));
    checks++; if (count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got count=%0d ovf=%b exp 8/0", count, overflow); end
    for (int i = 8; i < 10; i++) write_one(2'b01, 32'h100 + DATA_W'(i));
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d exp 8", count); end
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd2) begin errors++; $display("FAIL ovf_drops: got ovf=%b drops=%0d exp 1/2", overflow, drop_count); end
    checks++; if (out_data !== 32'h100) begin errors++; $display("FAIL ovf_head: got %h exp 100", out_data); end
    for (int i = 0; i < 260; i++) write_one(2'b10, 32'hDEAD);
    checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL drop_saturate: got %0d exp 255", drop_count); end
    clear = 1'b1; in_flag = 1'b1; in_ctrl = 2'b01; out_ready = 1'b1;
    step();
    idle();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL clear: got count=%0d v=%b ovf=%b drops=%0d exp 0/0/0/0", count, out_valid, overflow, drop_count); end
  endtask

  task automatic test_full_rw();
    idle();
    for (int i = 0; i < 8; i++) write_one(2'b01, 32'h200 + DATA_W'(i));
    out_ready = 1'b1;
    write_one(2'b10, 32'h2FF);
    checks++; if (count !== 4'd8 || out_data !== 32'h201) begin errors++; $display("FAIL full_rw: got count=%0d head=%h exp 8/201", count, out_data); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL full_rw_nodrop: got ovf=%b drops=%0d exp 0/0", overflow, drop_count); end
    for (int i = 0; i < 7; i++) step();
    checks++; if (count !== 4'd1 || out_data !== 32'h2FF || out_src !== 1'b1) begin errors++; $display("FAIL full_rw_tail: got count=%0d d=%h s=%b exp 1/2ff/1", count, out_data, out_src); end
    step();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_rw_empty: got count=%0d v=%b exp 0/0", count, out_valid); end
    idle();
  endtask

  task automatic test_ignore();
    idle();
    out_ready = 1'b1;
    write_one(2'b00, 32'h11);
    write_one(2'b11, 32'h22);
    capture_en = 1'b0;
    write_one(2'b01, 32'h33);
    capture_en = 1'b1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL ignore: got count=%0d v=%b drops=%0d exp 0/0/0", count, out_valid, drop_count); end
    checks++; if (out_data !== 32'h2FF) begin errors++; $display("FAIL ignore_hold: got %h exp 2ff", out_data); end
    idle();
  endtask

`ifdef RESULT_SEQ_EN
  task automatic test_seq();
    logic [SEQ_W-1:0] exp_s [5];
    exp_s[0] = 2'd0; exp_s[1] = 2'd1; exp_s[2] = 2'd2; exp_s[3] = 2'd3; exp_s[4] = 2'd0;
    idle();
    reset = 1'b0; step(); reset = 1'b1; step();
    for (int i = 0; i < 5; i++) write_one(2'b01, 32'h40 + DATA_W'(i));
    write_one(2'b00, 32'h99);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL seq_count: got %0d exp 5", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_seq !== exp_s[i] || out_data !== 32'h40 + DATA_W'(i)) begin errors++; $display("FAIL seq%0d: got seq=%0d d=%h exp %0d/%h", i, out_seq, out_data, exp_s[i], 32'h40 + DATA_W'(i)); end
      step();
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_rw();
    test_ignore();
`ifdef RESULT_SEQ_EN
    test_seq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
